// File: rtl/kb_event_fifo_if.sv
// Scan-byte input and key-event output bundle for kb_event_fifo.
// master = byte source / event consumer, slave = the decoder FIFO itself.
interface kb_event_fifo_if;
  logic       scan_done_tick;
  logic [7:0] scan_out;
  logic       rd_key_code;
  logic       clr_ovf;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       kb_buf_empty;
  logic       kb_buf_full;
  logic       kb_ovf;

  modport master (
    output scan_done_tick, scan_out, rd_key_code, clr_ovf,
    input  key_code, key_ext, key_brk, kb_buf_empty, kb_buf_full, kb_ovf
  );

  modport slave (
    input  scan_done_tick, scan_out, rd_key_code, clr_ovf,
    output key_code, key_ext, key_brk, kb_buf_empty, kb_buf_full, kb_ovf
  );
endinterface

// File: rtl/kb_event_fifo.sv
// PS/2 scan-code decoder (make/break/E0) feeding a first-word-fall-through
// event FIFO, with typematic-repeat filter, prefix timeout and overflow flag.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen
// S_BRK     | F0 seen
// S_EXT_BRK | E0 F0 seen
module kb_event_fifo #(
  parameter int W_SIZE        = 2,
  parameter int REPORT_MAKE   = 1,
  parameter int FILTER_REPEAT = 1,
  parameter int PREFIX_TO     = 50000
) (
  input logic            i_clk,
  input logic            i_reset,
  kb_event_fifo_if.slave kb
);

  localparam int DEPTH = 2 ** W_SIZE;
  localparam int TO_W  = (PREFIX_TO > 1) ? $clog2(PREFIX_TO) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'((PREFIX_TO > 0) ? PREFIX_TO - 1 : 0);
  localparam logic [W_SIZE:0]   CNT_FULL = (W_SIZE + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_to_hit;
  logic              w_ignored;
  logic              w_ev_valid;
  logic              w_ev_ext;
  logic              w_ev_brk;
  logic [9:0]        w_ev_word;

  logic [8:0]        r_last;
  logic              r_last_vld;
  logic              w_match;
  logic              w_make_new;
  logic              w_push;

  logic [9:0]        r_mem [DEPTH];
  logic [W_SIZE-1:0] r_wr_ptr;
  logic [W_SIZE-1:0] r_rd_ptr;
  logic [W_SIZE:0]   r_cnt;
  logic              r_ovf;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;
  logic              w_ovf_set;

  always_comb begin
    w_ignored = 1'b0;
    case (kb.scan_out)
      8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: w_ignored = 1'b1;
      default:                                          w_ignored = 1'b0;
    endcase
  end

  // Timeout fires on the clock whose increment would reach PREFIX_TO.
  assign w_to_hit = (PREFIX_TO != 0) && (r_state != S_IDLE) && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (kb.scan_done_tick || (r_state == S_IDLE) || w_to_hit) r_to_cnt <= '0;
      else                                                     r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ev_valid  = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_brk    = 1'b0;
    if (kb.scan_done_tick) begin
      if (w_ignored) begin
        w_state_nxt = S_IDLE;
      end else if (kb.scan_out == 8'hE0) begin
        w_state_nxt = S_EXT;
      end else if (kb.scan_out == 8'hF0) begin
        w_state_nxt = ((r_state == S_EXT) || (r_state == S_EXT_BRK)) ? S_EXT_BRK : S_BRK;
      end else begin
        w_ev_valid  = 1'b1;
        w_ev_ext    = (r_state == S_EXT) || (r_state == S_EXT_BRK);
        w_ev_brk    = (r_state == S_BRK) || (r_state == S_EXT_BRK);
        w_state_nxt = S_IDLE;
      end
    end else if (w_to_hit) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign w_ev_word  = {w_ev_ext, w_ev_brk, kb.scan_out};
  assign w_match    = r_last_vld && (r_last == {w_ev_ext, kb.scan_out});
  assign w_make_new = w_ev_valid && !w_ev_brk && !((FILTER_REPEAT != 0) && w_match);
  assign w_push     = (w_make_new && (REPORT_MAKE != 0)) || (w_ev_valid && w_ev_brk);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_make_new) begin
      r_last     <= {w_ev_ext, kb.scan_out};
      r_last_vld <= 1'b1;
    end else if (w_ev_valid && w_ev_brk && w_match) begin
      r_last_vld <= 1'b0;
    end
  end

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_FULL);
  assign w_pop     = kb.rd_key_code && !w_empty;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_ev_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (kb.clr_ovf)  r_ovf <= 1'b0;
    end
  end

  // Head is masked while empty so the RAM needs no reset.
  assign kb.key_code     = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
  assign kb.key_brk      = w_empty ? 1'b0  : r_mem[r_rd_ptr][8];
  assign kb.key_ext      = w_empty ? 1'b0  : r_mem[r_rd_ptr][9];
  assign kb.kb_buf_empty = w_empty;
  assign kb.kb_buf_full  = w_full;
  assign kb.kb_ovf       = r_ovf;

endmodule

// File: tb/tb_kb_event_fifo.sv
// Directed bench: filtering instance (u_dut_f) and non-filtering instance
// (u_dut_n) share the byte stream; head words are {ext,brk,code}.
module tb_kb_event_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  kb_event_fifo_if if_f();
  kb_event_fifo_if if_n();

  kb_event_fifo #(.W_SIZE(2), .REPORT_MAKE(1), .FILTER_REPEAT(1), .PREFIX_TO(10)) u_dut_f (
    .i_clk(clk), .i_reset(reset), .kb(if_f)
  );
  kb_event_fifo #(.W_SIZE(2), .REPORT_MAKE(1), .FILTER_REPEAT(0), .PREFIX_TO(10)) u_dut_n (
    .i_clk(clk), .i_reset(reset), .kb(if_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] head_f();
    return {if_f.key_ext, if_f.key_brk, if_f.key_code};
  endfunction

  function automatic logic [9:0] head_n();
    return {if_n.key_ext, if_n.key_brk, if_n.key_code};
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b);
    if_f.scan_done_tick = 1'b1; if_f.scan_out = b;
    if_n.scan_done_tick = 1'b1; if_n.scan_out = b;
    @(negedge clk);
    if_f.scan_done_tick = 1'b0;
    if_n.scan_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(input bit pf, input bit pn);
    if_f.rd_key_code = pf;
    if_n.rd_key_code = pn;
    @(negedge clk);
    if_f.rd_key_code = 1'b0;
    if_n.rd_key_code = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] b);
    if_f.rd_key_code = 1'b1; if_n.rd_key_code = 1'b1;
    send(b);
    if_f.rd_key_code = 1'b0; if_n.rd_key_code = 1'b0;
  endtask

  task automatic pop_chk_f(input string tag, input logic [9:0] exp);
    check(tag, 32'(head_f()), 32'(exp));
    pop(1'b1, 1'b0);
  endtask

  task automatic pop_chk_n(input string tag, input logic [9:0] exp);
    check(tag, 32'(head_n()), 32'(exp));
    pop(1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) pop(1'b1, 1'b1);
  endtask

  task automatic set_clr(input logic v);
    if_f.clr_ovf = v;
    if_n.clr_ovf = v;
  endtask

  initial begin
    if_f.scan_done_tick = 1'b0; if_f.scan_out = 8'h00; if_f.rd_key_code = 1'b0; if_f.clr_ovf = 1'b0;
    if_n.scan_done_tick = 1'b0; if_n.scan_out = 8'h00; if_n.rd_key_code = 1'b0; if_n.clr_ovf = 1'b0;
    idle(3);
    check("rst_empty", 32'(if_f.kb_buf_empty), 32'd1);
    check("rst_full",  32'(if_f.kb_buf_full),  32'd0);
    check("rst_ovf",   32'(if_f.kb_ovf),       32'd0);
    check("rst_head",  32'(head_f()),          32'h000);
    reset = 1'b0;

    // make / break
    send(8'h1C); send(8'hF0); send(8'h1C);
    pop_chk_f("mb_make", 10'h01C);
    pop_chk_f("mb_brk",  10'h11C);
    check("mb_empty", 32'(if_f.kb_buf_empty), 32'd1);
    drain();

    // extended make / break, then plain key proves return to IDLE
    send(8'hE0); send(8'h75);
    pop_chk_f("ext_make", 10'h275);
    send(8'hE0); send(8'hF0); send(8'h75);
    pop_chk_f("ext_brk", 10'h375);
    send(8'h74);
    pop_chk_f("ext_idle", 10'h074);
    check("ext_empty", 32'(if_f.kb_buf_empty), 32'd1);
    drain();

    // typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("typ_n_full", 32'(if_n.kb_buf_full), 32'd0);
    pop_chk_n("typ_n_ev0", 10'h01C);
    pop_chk_n("typ_n_ev1", 10'h01C);
    pop_chk_n("typ_n_ev2", 10'h01C);
    send(8'hF0); send(8'h1C); send(8'h1C);
    pop_chk_n("typ_n_ev3", 10'h11C);
    pop_chk_n("typ_n_ev4", 10'h01C);
    check("typ_n_empty", 32'(if_n.kb_buf_empty), 32'd1);
    pop_chk_f("typ_f_ev0", 10'h01C);
    pop_chk_f("typ_f_ev1", 10'h11C);
    pop_chk_f("typ_f_ev2", 10'h01C);
    check("typ_f_empty", 32'(if_f.kb_buf_empty), 32'd1);
    drain();

    // overflow
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    check("ovf_full", 32'(if_f.kb_buf_full), 32'd1);
    check("ovf_flag", 32'(if_f.kb_ovf),      32'd1);
    check("ovf_head", 32'(head_f()),         32'h015);
    push_pop(8'h1B);
    check("pp_full", 32'(if_f.kb_buf_full), 32'd1);
    check("pp_head", 32'(head_f()),         32'h01D);
    check("pp_ovf",  32'(if_f.kb_ovf),      32'd1);
    set_clr(1'b1); idle(1); set_clr(1'b0);
    check("clr_ovf",  32'(if_f.kb_ovf),      32'd0);
    check("clr_full", 32'(if_f.kb_buf_full), 32'd1);
    set_clr(1'b1); send(8'h3C); set_clr(1'b0);
    check("ovf_set_wins", 32'(if_f.kb_ovf), 32'd1);
    set_clr(1'b1); idle(1); set_clr(1'b0);
    pop_chk_f("ovf_q0", 10'h01D);
    pop_chk_f("ovf_q1", 10'h024);
    pop_chk_f("ovf_q2", 10'h02D);
    pop_chk_f("ovf_q3", 10'h01B);
    check("ovf_empty", 32'(if_f.kb_buf_empty), 32'd1);
    pop(1'b1, 1'b0);
    check("pop_empty", 32'(if_f.kb_buf_empty), 32'd1);
    push_pop(8'h16);
    check("pp_empty_flag", 32'(if_f.kb_buf_empty), 32'd0);
    pop_chk_f("pp_empty_head", 10'h016);
    drain();

    // prefix timeout and ignored bytes
    send(8'hF0); idle(10); send(8'h1C);
    pop_chk_f("to_make", 10'h01C);
    send(8'hF0); idle(9); send(8'h1C);
    pop_chk_f("to_edge_brk", 10'h11C);
    send(8'hF0); send(8'hAA); send(8'h1C);
    pop_chk_f("ign_make", 10'h01C);
    send(8'hE0); send(8'hFA); send(8'h5A);
    pop_chk_f("ign_ext", 10'h05A);
    drain();

    // reset in the middle of a prefix
    send(8'h55);
    check("pre_rst_head", 32'(head_f()), 32'h055);
    send(8'hE0); send(8'hF0);
    reset = 1'b1;
    idle(1);
    check("mid_rst_empty", 32'(if_f.kb_buf_empty), 32'd1);
    check("mid_rst_head",  32'(head_f()),          32'h000);
    idle(1);
    reset = 1'b0;
    send(8'h74);
    pop_chk_f("rst_mid_ev", 10'h074);
    check("rst_mid_empty", 32'(if_f.kb_buf_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/kb_event_fifo.md
Name: kb_event_fifo

Overview:
Parametrised keyboard scan-code decoder and event buffer. It consumes the byte stream from the PS/2 receiver (rx_done_tick, dout) and decodes make, break and extended (E0) sequences into 10-bit key events. Events are queued in a first-word-fall-through FIFO for the downstream display/sequence logic. Optional typematic-repeat filtering, a prefix timeout and overflow reporting are provided.

Parameters:
W_SIZE, 2, FIFO address bits; depth = 2**W_SIZE entries.
REPORT_MAKE, 1, 1 = push make events; 0 = push break events only.
FILTER_REPEAT, 1, 1 = suppress repeated make of the key held down.
PREFIX_TO, 50000, clocks without a byte before a prefix state aborts to IDLE; 0 = timeout disabled.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
scan_done_tick  in  1  one-cycle strobe: scan_out is valid
scan_out  in  8  received scan byte
rd_key_code  in  1  pop head event; ignored when empty
clr_ovf  in  1  clears kb_ovf
key_code  out  8  head event scan code (valid when !kb_buf_empty)
key_ext  out  1  head event had E0 prefix
key_brk  out  1  head event is break (release)
kb_buf_empty  out  1  FIFO empty
kb_buf_full  out  1  FIFO full
kb_ovf  out  1  sticky: an event was dropped because FIFO was full

Behaviour:
- Reset (sync, active-high): state IDLE, FIFO pointers 0, kb_buf_empty=1, kb_buf_full=0, kb_ovf=0, key_code/key_ext/key_brk=0, last-make register invalid, timeout counter 0. Reset mid-sequence discards partial prefixes.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Acts only on cycles with scan_done_tick=1.
  IDLE: E0->EXT; F0->BRK; ignored byte->IDLE; other->make event {ext=0}.
  EXT: F0->EXT_BRK; E0->EXT; ignored byte->IDLE; other->make event {ext=1}, ->IDLE.
  BRK: E0->EXT (resync); F0->BRK; ignored byte->IDLE; other->break event {ext=0}, ->IDLE.
  EXT_BRK: E0->EXT; F0->EXT_BRK; ignored byte->IDLE; other->break event {ext=1}, ->IDLE.
- Ignored bytes: E1, AA, FA, FE, EE, 00, FF. They produce no event. From IDLE they leave the state in IDLE; from any prefix state they return it to IDLE.
- Event push: the event word {ext,brk,code} is written in the same cycle as scan_done_tick and is visible at the FIFO head the next cycle if the FIFO was empty (latency 1 clock).
- Make events push only if REPORT_MAKE=1.
- Repeat filter (FILTER_REPEAT=1): a make whose {ext,code} equals the last-make register is dropped. An accepted make loads the register. A break matching the register invalidates it. A break for a different key leaves it unchanged.
- Timeout: the counter clears on every scan_done_tick and increments while the FSM is in any non-IDLE state. When it reaches PREFIX_TO, the FSM returns to IDLE and the counter clears. It is disabled when PREFIX_TO=0.
- FIFO: first-word-fall-through; outputs reflect the head entry combinationally from the registered array. rd_key_code while empty: no effect. Push and pop in the same cycle when full: both succeed, count unchanged. Push without pop when full: event dropped, kb_ovf<=1. Push and pop in the same cycle when empty: push succeeds, pop ignored. Pointers wrap modulo 2**W_SIZE.
- kb_ovf: held until clr_ovf=1 or reset. If clr_ovf=1 and a new overflow occur in the same cycle, set wins.

Test Plan:
- Make/break, REPORT_MAKE=1: bytes 1C, F0, 1C -> two events {0,0,1C} then {0,1,1C}; after the pops, kb_buf_empty=1.
- Extended key: E0 75, E0 F0 75 -> {1,0,75}, {1,1,75}; state returns to IDLE after each event.
- Typematic: 1C, 1C, 1C, F0, 1C, 1C -> events {0,0,1C}, {0,1,1C}, {0,0,1C}; the two repeats are dropped. With FILTER_REPEAT=0 -> 6 bytes yield 5 events.
- Overflow, W_SIZE=2, no reads: 5 make codes (15,1D,24,2D,2C) -> kb_buf_full=1, kb_ovf=1, head 15. Pop-and-push while full keeps the count at 4. clr_ovf clears kb_ovf.
- Prefix timeout, PREFIX_TO=10: F0 then 10 idle clocks then 1C -> make {0,0,1C}, not a break. Ignored byte: F0, AA, 1C -> make {0,0,1C}.
- Reset mid-sequence: E0, F0, reset pulse, 74 -> single event {0,0,74}. Outputs are 0 and kb_buf_empty=1 during reset.
